vec_loop_ctrl: RTL and testbench
================================

Name: vec_loop_ctrl

Overview:
- Scalar-register and loop sequencer behind the ID-stage instruction decoder.
- Owns the I, J and N scalar registers and applies the decoder's scalar-register op (INCRI, INCRJ, SETN).
- Sequences the multi-cycle vector ops SUMFV/MULFV by issuing N element requests to the vector unit with ready/valid handshake.
- Holds off new instructions (in_ready low) while a vector op is in flight.

Parameters:
- IDX_W, 8, width of I, J, N and element index; SETN loads imm[IDX_W-1:0].
- IMM_W, 24, width of decoder immediate.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present this cycle.
- in_ready  output  1  controller can accept an instruction.
- opcode  input  4  instruction bits [31:28].
- sca_reg_op  input  2  decoder op: 00 INCRI, 01 INCRJ, 10 SETN, 11 other.
- imm  input  IMM_W  decoder immediate.
- i_val  output  IDX_W  scalar register I.
- j_val  output  IDX_W  scalar register J.
- n_val  output  IDX_W  scalar register N (vector length).
- elem_valid  output  1  element request to vector unit.
- elem_ready  input  1  vector unit accepts element.
- elem_idx  output  IDX_W  element index of current request.
- vec_mul  output  1  0 = SUMFV, 1 = MULFV; stable while busy.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at vector-op completion.
- illegal  output  1  one-cycle pulse on accepted opcode > 4'b0101.

Behaviour:
- Reset (rst=0, async): state IDLE. i_val, j_val, n_val, elem_idx, vec_mul = 0. elem_valid, done, illegal, busy = 0. in_ready = 1 after release.
- Acceptance: instruction accepted when in_valid & in_ready. in_ready = (state==IDLE), combinational from state only.
- Effects of an accepted instruction, registered on the next edge:
  - sca_reg_op 00: I <= I+1, wraps modulo 2^IDX_W.
  - sca_reg_op 01: J <= J+1, wraps modulo 2^IDX_W.
  - sca_reg_op 10: N <= imm[IDX_W-1:0]; upper imm bits ignored.
  - sca_reg_op 11 with opcode 0011: vec_mul <= 0, enter vector op.
  - sca_reg_op 11 with opcode 0100: vec_mul <= 1, enter vector op.
  - sca_reg_op 11 with opcode 0101: NOP, no state change.
  - sca_reg_op 11 with any other opcode: treated as NOP; illegal pulses high the following cycle.
- Entering a vector op: elem_idx <= 0. If N==0, go to DONE (no element issued); otherwise go to RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE: wait for accepted instruction.
  - RUN: elem_valid=1, elem_idx = current count.
    - On elem_ready: if elem_idx==N-1, go to DONE; else elem_idx++.
    - Without elem_ready: hold elem_idx, elem_valid stays 1 (no retraction).
  - DONE: done=1 for exactly one cycle, elem_valid=0, in_ready=0; then IDLE.
- Latency: vector op accepted at cycle t; first element at t+1; done = t+1+N+stall_cycles; next instruction accepted at done+1. Scalar ops take effect at t+1 and keep in_ready high (back-to-back allowed).
- Boundaries:
  - N is frozen during RUN, since no instruction is accepted while busy.
  - N == 2^IDX_W-1 issues indices 0..N-1 with no overflow.
  - I/J wrap 0xFF->0x00 silently.
  - Ignore in_valid and all inputs while not IDLE.
  - rst mid-RUN aborts immediately: elem_valid drops asynchronously, no done pulse.
- vec_mul and the element count are registered, with no combinational path from opcode to elem_*.

Decomposition:
- Package vec_ctrl_pkg holds:
  - typedef enum for sca_reg_op (SCA_INCRI, SCA_INCRJ, SCA_SETN, SCA_OTHER);
  - opcode constants OP_SUMFV=4'b0011, OP_MULFV=4'b0100, OP_NOP=4'b0101;
  - FSM state enum {ST_IDLE, ST_RUN, ST_DONE}.
- One natural sub-module: vec_elem_counter (load/enable/terminal-count counter, IDX_W wide), used for elem_idx.

Test Plan:
- Reset then INCRI x3, INCRJ x1 back-to-back with in_valid held -> i_val=3, j_val=1, in_ready stays 1.
- SETN imm=24'hABC005 (IDX_W=8) -> n_val=8'h05. Then SUMFV -> elem_idx 0..4 on consecutive cycles with elem_ready=1; done at accept+6; vec_mul=0.
- MULFV with N=3, elem_ready low 2 cycles on idx 1 -> idx 1 held with elem_valid=1 for 3 cycles; done at accept+6; vec_mul=1; new in_valid ignored until in_ready returns.
- SETN 0 then SUMFV -> no elem_valid; done pulses at accept+1; in_ready high at accept+2.
- I at 8'hFF + INCRI -> 8'h00. Opcode 4'b1110 with sca_reg_op=11 -> illegal one-cycle pulse, registers unchanged.
- rst low during RUN at idx 2 of N=6 -> elem_valid, busy, elem_idx, n_val go to 0 immediately; no done; in_ready=1 after release.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// Shared types and constants for the vector loop controller.
//   sca_op_e  : decoder scalar-register op field
//   OP_*      : opcode values (instruction bits [31:28]) the controller decodes
//   state_e   : sequencer FSM states
package vec_ctrl_pkg;

    typedef enum logic [1:0] {
        SCA_INCRI = 2'b00,
        SCA_INCRJ = 2'b01,
        SCA_SETN  = 2'b10,
        SCA_OTHER = 2'b11
    } sca_op_e;

    localparam logic [3:0] OP_SUMFV = 4'b0011;
    localparam logic [3:0] OP_MULFV = 4'b0100;
    localparam logic [3:0] OP_NOP   = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/vec_elem_counter.sv
// Element index counter for vector-op sequencing.
//   clk, rst : clock, asynchronous active-low reset
//   load     : restart the count at zero (takes priority over en)
//   en       : advance the count by one
//   term     : terminal value (last element index)
//   count    : current element index
//   tc       : count has reached term
module vec_elem_counter #(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [IDX_W-1:0] term,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE_IDX;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/vec_loop_ctrl.sv
// Scalar-register and loop sequencer behind the ID-stage decoder.
// Owns I/J/N, applies INCRI/INCRJ/SETN, and issues N element requests to the
// vector unit for SUMFV/MULFV with a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : decoded instruction handshake (ready only when idle)
//   opcode, sca_reg_op, imm : decoded instruction fields
//   i_val, j_val, n_val : scalar registers
//   elem_valid/elem_ready, elem_idx : element request to the vector unit
//   vec_mul           : 0 = SUMFV, 1 = MULFV, stable while busy
//   busy, done        : sequencer active / one-cycle completion pulse
//   illegal           : one-cycle pulse after an accepted undefined opcode
module vec_loop_ctrl
    import vec_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned IMM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [1:0]       sca_reg_op,
    input  logic [IMM_W-1:0] imm,
    output logic [IDX_W-1:0] i_val,
    output logic [IDX_W-1:0] j_val,
    output logic [IDX_W-1:0] n_val,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic [IDX_W-1:0] elem_idx,
    output logic             vec_mul,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    state_e           state;
    sca_op_e          sop;
    logic             accept;
    logic             is_vec;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_tc;
    logic [IDX_W-1:0] cnt_term;

    // Only the low IDX_W immediate bits are architecturally visible.
    logic unused_imm;
    assign unused_imm = ^imm[IMM_W-1:IDX_W];

    assign sop    = sca_op_e'(sca_reg_op);
    assign accept = in_valid & in_ready;
    assign is_vec = (sop == SCA_OTHER) && ((opcode == OP_SUMFV) || (opcode == OP_MULFV));

    always_comb begin
        cnt_load = accept & is_vec;
        cnt_en   = (state == ST_RUN) & elem_ready & ~cnt_tc;
        // N==0 never reaches RUN, so the wrapped term for N==0 is never used.
        cnt_term = n_val - ONE_IDX;
    end

    vec_elem_counter #(
        .IDX_W (IDX_W)
    ) u_elem_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .en    (cnt_en),
        .term  (cnt_term),
        .count (elem_idx),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            i_val   <= '0;
            j_val   <= '0;
            n_val   <= '0;
            vec_mul <= 1'b0;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (sop)
                            SCA_INCRI: i_val <= i_val + ONE_IDX;
                            SCA_INCRJ: j_val <= j_val + ONE_IDX;
                            SCA_SETN:  n_val <= imm[IDX_W-1:0];
                            default: begin
                                if (is_vec) begin
                                    vec_mul <= (opcode == OP_MULFV);
                                    state   <= (n_val == '0) ? ST_DONE : ST_RUN;
                                end else if (opcode > OP_NOP) begin
                                    // Undefined opcode: behaves as NOP but is flagged.
                                    illegal <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (elem_ready && cnt_tc) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded straight from the state register; reset clears them asynchronously.
    assign in_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign elem_valid = (state == ST_RUN);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_vec_loop_ctrl.sv
module tb_vec_loop_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [1:0]  sca_reg_op;
    logic [23:0] imm;
    logic [7:0]  i_val;
    logic [7:0]  j_val;
    logic [7:0]  n_val;
    logic        elem_valid;
    logic        elem_ready;
    logic [7:0]  elem_idx;
    logic        vec_mul;
    logic        busy;
    logic        done;
    logic        illegal;

    vec_loop_ctrl #(
        .IDX_W (8),
        .IMM_W (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .sca_reg_op (sca_reg_op),
        .imm        (imm),
        .i_val      (i_val),
        .j_val      (j_val),
        .n_val      (n_val),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_idx   (elem_idx),
        .vec_mul    (vec_mul),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Scoreboard entry kinds: 0 element handshake, 1 done pulse, 2 illegal pulse.
    typedef struct {
        int         kind;
        logic [7:0] idx;
        logic       mul;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    logic [7:0] exp_i = 8'h00;
    logic [7:0] exp_j = 8'h00;
    logic [7:0] exp_n = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] idx, input logic mul, input int c);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.mul  = mul;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        bit   ok;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL monitor: unexpected event kind %0d at cycle %0d, idx %0h", kind, cyc,
                     elem_idx);
        end else begin
            e  = sb.pop_front();
            ok = (e.kind == kind) && (kind != 0 || e.idx == elem_idx) &&
                 (kind == 2 || e.mul == vec_mul) && (e.cyc < 0 || e.cyc == cyc);
            if (!ok) begin
                fails++;
                $display("FAIL monitor: got kind %0d idx %0h mul %0b cyc %0d, expected kind %0d idx %0h mul %0b cyc %0d",
                         kind, elem_idx, vec_mul, cyc, e.kind, e.idx, e.mul, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (elem_valid && elem_ready) check_evt(0);
            if (done) check_evt(1);
            if (illegal) check_evt(2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, wait (bounded) for acceptance; leaves in_valid as is.
    task automatic issue(input logic [3:0] opc, input logic [1:0] sop, input logic [23:0] im,
                         output int t);
        int waited;
        opcode     = opc;
        sca_reg_op = sop;
        imm        = im;
        in_valid   = 1'b1;
        waited     = 0;
        while (!in_ready && waited < 1000) begin
            tick();
            waited++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        t = cyc;
        tick();
        unique case (sop)
            2'b00:   exp_i = exp_i + 8'd1;
            2'b01:   exp_j = exp_j + 8'd1;
            2'b10:   exp_n = im[7:0];
            default: ;
        endcase
    endtask

    task automatic run_vec(input logic [3:0] opc, input int stall_idx, input int stall_cnt,
                           input bit junk);
        int t;
        int k;
        int rem;
        int n;
        logic mul;
        n   = int'(exp_n);
        mul = (opc == 4'b0100);
        issue(opc, 2'b11, 24'h0, t);
        if (junk) begin
            sca_reg_op = 2'b00;
            in_valid   = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        for (int e = 0; e < n; e++) push(0, 8'(e), mul, -1);
        push(1, 8'h0, mul, t + 1 + n + ((n > 0) ? stall_cnt : 0));
        k   = 0;
        rem = stall_cnt;
        while (k < n) begin
            chk("elem_valid", 32'(elem_valid), 32'd1);
            chk("elem_idx", 32'(elem_idx), 32'(k));
            if (k == stall_idx && rem > 0) begin
                elem_ready = 1'b0;
                rem--;
            end else begin
                elem_ready = 1'b1;
                k++;
            end
            tick();
        end
        elem_ready = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_no_elem", 32'(elem_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("post_done_ready", 32'(in_ready), 32'd1);
        chk("post_done_busy", 32'(busy), 32'd0);
        chk("post_done_i", 32'(i_val), 32'(exp_i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst        = 1'b1;
        in_valid   = 1'b0;
        opcode     = 4'h0;
        sca_reg_op = 2'b00;
        imm        = 24'h0;
        elem_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_i", 32'(i_val), 32'd0);
        chk("rst_j", 32'(j_val), 32'd0);
        chk("rst_n", 32'(n_val), 32'd0);
        chk("rst_idx", 32'(elem_idx), 32'd0);
        chk("rst_outs", {28'd0, elem_valid, done, illegal, busy}, 32'd0);
        chk("rst_mul", 32'(vec_mul), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Back-to-back scalar ops with in_valid held.
        for (int r = 0; r < 3; r++) begin
            issue(4'h0, 2'b00, 24'h0, t);
            chk("scalar_ready", 32'(in_ready), 32'd1);
        end
        issue(4'h0, 2'b01, 24'h0, t);
        in_valid = 1'b0;
        chk("incri_x3", 32'(i_val), 32'd3);
        chk("incrj_x1", 32'(j_val), 32'd1);
        chk("scalar_ready_end", 32'(in_ready), 32'd1);

        // SETN drops upper immediate bits, then a 5-element SUMFV.
        issue(4'h0, 2'b10, 24'hABC005, t);
        in_valid = 1'b0;
        chk("setn_abc005", 32'(n_val), 32'h05);
        run_vec(4'b0011, -1, 0, 1'b0);

        // MULFV N=3 with a 2-cycle stall on idx 1; junk INCRI held while busy.
        issue(4'h0, 2'b10, 24'h000003, t);
        in_valid = 1'b0;
        run_vec(4'b0100, 1, 2, 1'b1);
        chk("mulfv_i_unchanged", 32'(i_val), 32'd3);

        // N=0: done pulses immediately, no element issued.
        issue(4'h0, 2'b10, 24'h000000, t);
        in_valid = 1'b0;
        run_vec(4'b0011, -1, 0, 1'b0);

        // Drive I up to 0xFF, then wrap.
        while (exp_i != 8'hFF) issue(4'h0, 2'b00, 24'h0, t);
        in_valid = 1'b0;
        chk("i_at_ff", 32'(i_val), 32'hFF);
        issue(4'h0, 2'b00, 24'h0, t);
        in_valid = 1'b0;
        chk("i_wrap", 32'(i_val), 32'h00);

        // NOP: nothing changes, no illegal pulse (monitor would flag one).
        issue(4'b0101, 2'b11, 24'h0, t);
        in_valid = 1'b0;
        chk("nop_busy", 32'(busy), 32'd0);

        // Undefined opcode: illegal pulse, registers untouched.
        issue(4'b1110, 2'b11, 24'h0, t);
        in_valid = 1'b0;
        push(2, 8'h0, 1'b0, t + 1);
        chk("illegal_pulse", 32'(illegal), 32'd1);
        chk("illegal_regs", {8'd0, i_val, j_val, n_val}, {8'd0, 8'h00, 8'h01, 8'h00});
        tick();
        chk("illegal_one_cycle", 32'(illegal), 32'd0);

        // Maximum length vector: indices 0..254.
        issue(4'h0, 2'b10, 24'h0000FF, t);
        in_valid = 1'b0;
        run_vec(4'b0011, -1, 0, 1'b0);

        // Reset mid-run at idx 2 of N=6.
        issue(4'h0, 2'b10, 24'h000006, t);
        issue(4'b0011, 2'b11, 24'h0, t);
        in_valid = 1'b0;
        push(0, 8'h00, 1'b0, -1);
        push(0, 8'h01, 1'b0, -1);
        elem_ready = 1'b1;
        tick();
        tick();
        elem_ready = 1'b0;
        chk("pre_rst_idx", 32'(elem_idx), 32'd2);
        chk("pre_rst_valid", 32'(elem_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_run_valid", 32'(elem_valid), 32'd0);
        chk("rst_run_busy", 32'(busy), 32'd0);
        chk("rst_run_idx", 32'(elem_idx), 32'd0);
        chk("rst_run_n", 32'(n_val), 32'd0);
        chk("rst_run_done", 32'(done), 32'd0);
        exp_i = 8'h00;
        exp_j = 8'h00;
        exp_n = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_run_ready", 32'(in_ready), 32'd1);
        repeat (4) tick();
        chk("rst_run_no_done", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
